// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and colour type, used by both the timing
// generator and pixel_gen so the two agree on the scan geometry.
package vga_pkg;

    localparam int VGA_PCLK_DIV = 4;

    localparam int VGA_H_DISP   = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_DISP   = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [11:0] color_t;

    localparam color_t VGA_BG_COLOR = 12'hFFF;

    // Half-open window test [lo, hi); one bit wider than the counters so that
    // hi == 1024 does not wrap.
    function automatic logic in_window(
        input logic [10:0] cnt,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vga_pclk_div.sv
// Pixel-clock divider: counts 0..PCLK_DIV-1 on the system clock and flags the
// last system clock of every pixel period.
module vga_pclk_div
    import vga_pkg::*;
#(
    parameter int PCLK_DIV = VGA_PCLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pclk_tick
);

    localparam int DW = $clog2(PCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);

    logic [DW-1:0] div_r;

    // Free-running divider, restarted from zero by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= DIV_ZERO;
        end else if (div_r == DIV_LAST) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    assign pclk_tick = (div_r == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source and output stage: scan counters, registered sync pulses and
// blanked RGB, all advancing once per pixel tick.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int     PCLK_DIV = VGA_PCLK_DIV,
    parameter int     H_DISP   = VGA_H_DISP,
    parameter int     H_FP     = VGA_H_FP,
    parameter int     H_SYNC   = VGA_H_SYNC,
    parameter int     H_BP     = VGA_H_BP,
    parameter int     V_DISP   = VGA_V_DISP,
    parameter int     V_FP     = VGA_V_FP,
    parameter int     V_SYNC   = VGA_V_SYNC,
    parameter int     V_BP     = VGA_V_BP,
    parameter color_t BG_COLOR = VGA_BG_COLOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_in,
    input  logic        show_data_in,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        pclk_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_DISP);
    localparam logic [10:0] V_ACT    = 11'(V_DISP);
    localparam logic [10:0] HS_START = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_DISP + V_FP + V_SYNC);

    logic        pclk_tick_s;
    logic [9:0]  h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic        valid_s;
    logic        hs_active_s;
    logic        vs_active_s;
    color_t      rgb_next_s;
    logic        hsync_r;
    logic        vsync_r;
    color_t      rgb_r;

    vga_pclk_div #(
        .PCLK_DIV (PCLK_DIV)
    ) u_pclk_div (
        .clk       (clk),
        .rst       (rst),
        .pclk_tick (pclk_tick_s)
    );

    // Scan counters: column wraps at the end of the line and carries into the line counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (pclk_tick_s) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= 10'd0;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= 10'd0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end
        end
    end

    // Decode of the current (pre-increment) scan position.
    always_comb begin
        valid_s     = in_window({1'b0, h_cnt_r}, 11'd0, H_ACT) &&
                      in_window({1'b0, v_cnt_r}, 11'd0, V_ACT);
        hs_active_s = in_window({1'b0, h_cnt_r}, HS_START, HS_END);
        vs_active_s = in_window({1'b0, v_cnt_r}, VS_START, VS_END);
        rgb_next_s  = 12'h000;
        if (valid_s) begin
            if (show_data_in) begin
                rgb_next_s = pixel_in;
            end else begin
                rgb_next_s = BG_COLOR;
            end
        end else begin
            rgb_next_s = 12'h000;
        end
    end

    // Output stage, one pixel behind the counters so sync and colour stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            rgb_r   <= 12'h000;
        end else if (pclk_tick_s) begin
            hsync_r <= ~hs_active_s;
            vsync_r <= ~vs_active_s;
            rgb_r   <= rgb_next_s;
        end
    end

    assign h_cnt       = h_cnt_r;
    assign v_cnt       = v_cnt_r;
    assign valid       = valid_s;
    assign pclk_tick   = pclk_tick_s;
    assign frame_start = pclk_tick_s && (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign vga_r       = rgb_r[11:8];
    assign vga_g       = rgb_r[7:4];
    assign vga_b       = rgb_r[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced scan geometry (25x15 pixels, divide by 4)
// so whole frames fit in a short run; expected outputs go through a scoreboard queue.
module tb_vga_timing_gen;

    localparam int P  = 4;
    localparam int HD = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VD = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int F  = HT * VT * P;
    localparam logic [11:0] BG = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pixel_in;
    logic        show_data_in;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        pclk_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    vga_timing_gen #(
        .PCLK_DIV (P),
        .H_DISP   (HD),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_DISP   (VD),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .BG_COLOR (BG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (pixel_in),
        .show_data_in (show_data_in),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .valid        (valid),
        .pclk_tick    (pclk_tick),
        .frame_start  (frame_start),
        .hsync        (hsync),
        .vsync        (vsync),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        int          h;
        int          v;
    } exp_t;

    exp_t sb_q[$];

    int n_tests;
    int n_fail;
    int m_div, m_h, m_v;
    int cyc, last_fs, first_fs, fs_count;
    int hs_low, hs_first, hs_last;
    int vs_low, vs_first;
    int blank_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h"},     {22'd0, h_cnt}, 32'd0);
        check({tag, "_v"},     {22'd0, v_cnt}, 32'd0);
        check({tag, "_hsync"}, {31'd0, hsync}, 32'd1);
        check({tag, "_vsync"}, {31'd0, vsync}, 32'd1);
        check({tag, "_rgb"},   {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        check({tag, "_tick"},  {31'd0, pclk_tick}, 32'd0);
        check({tag, "_fs"},    {31'd0, frame_start}, 32'd0);
    endtask

    task automatic reset_model();
        m_div = 0; m_h = 0; m_v = 0;
        cyc = 0; last_fs = -1; first_fs = -1; fs_count = 0;
        sb_q.delete();
    endtask

    // One system clock: push the expectation for a tick, then compare after the edge.
    task automatic step();
        logic tk;
        exp_t e;
        tk = (m_div == P - 1);
        if (tk) begin
            e.hs  = !(m_h >= HD + HF && m_h < HD + HF + HS);
            e.vs  = !(m_v >= VD + VF && m_v < VD + VF + VS);
            e.rgb = (m_h < HD && m_v < VD) ? (show_data_in ? pixel_in : BG) : 12'h000;
            e.h   = m_h;
            e.v   = m_v;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (tk) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        m_div = tk ? 0 : m_div + 1;

        check("h_cnt", {22'd0, h_cnt}, m_h);
        check("v_cnt", {22'd0, v_cnt}, m_v);
        check("pclk_tick", {31'd0, pclk_tick}, (m_div == P - 1));
        check("valid", {31'd0, valid}, (m_h < HD && m_v < VD));
        check("frame_start", {31'd0, frame_start}, (m_div == P - 1 && m_h == 0 && m_v == 0));
        if (m_h == HD - 1 && m_v == VD - 1) check("valid_last_active", {31'd0, valid}, 32'd1);
        if (m_h == HD && m_v == VD - 1)     check("valid_h_edge", {31'd0, valid}, 32'd0);
        if (m_h == 0 && m_v == VD)          check("valid_v_edge", {31'd0, valid}, 32'd0);

        if (frame_start) begin
            fs_count++;
            if (first_fs < 0) first_fs = cyc;
            if (last_fs >= 0) check("frame_period", cyc - last_fs, F);
            last_fs = cyc;
        end

        if (tk) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("hsync", {31'd0, hsync}, {31'd0, e.hs});
                check("vsync", {31'd0, vsync}, {31'd0, e.vs});
                check("rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, e.rgb});
                if (fs_count == 1 && e.v == 3 && hsync == 1'b0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = e.h;
                    hs_last = e.h;
                end
                if (fs_count == 1 && e.h == 0 && vsync == 1'b0) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = e.v;
                end
                if ((e.h >= HD || e.v >= VD) && {vga_r, vga_g, vga_b} != 12'h000) blank_bad++;
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        hs_low = 0; hs_first = -1; hs_last = -1;
        vs_low = 0; vs_first = -1; blank_bad = 0;
        pixel_in = 12'h000;
        show_data_in = 1'b0;
        rst = 1'b1;
        reset_model();

        // Reset state, while held and across clock edges.
        #12;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_held");

        // Colour at (0,0): supplied pixel, then background.
        pixel_in = 12'hA5C;
        show_data_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (P) step();
        check("first_fs_cycle", first_fs, P - 1);
        check("rgb_r_a5c", {28'd0, vga_r}, 32'hA);
        check("rgb_g_a5c", {28'd0, vga_g}, 32'h5);
        check("rgb_b_a5c", {28'd0, vga_b}, 32'hC);
        show_data_in = 1'b0;
        repeat (P) step();
        check("rgb_bg", {20'd0, vga_r, vga_g, vga_b}, 32'hFFF);

        // White pixels held for two frames: blanking, sync windows, frame period.
        pixel_in = 12'hFFF;
        show_data_in = 1'b1;
        repeat (2 * F - 2 * P) step();
        check("fs_count_2frames", fs_count, 2);
        check("hsync_low_ticks", hs_low, HS);
        check("hsync_first_h", hs_first, HD + HF);
        check("hsync_last_h", hs_last, HD + HF + HS - 1);
        check("vsync_low_lines", vs_low, VS);
        check("vsync_first_v", vs_first, VD + VF);
        check("blank_rgb_zero", blank_bad, 0);

        // Asynchronous reset in the middle of an active line.
        for (int i = 0; i < 2 * F && !(m_h == 10 && m_v == 5 && m_div == 1); i++) step();
        check("reached_mid_frame", {31'd0, (m_h == 10 && m_v == 5)}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("mid_reset_held");
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        repeat (P) step();
        check("restart_fs_cycle", first_fs, P - 1);
        check("restart_h", {22'd0, h_cnt}, 32'd1);
        repeat (F) step();
        check("fs_count_restart", fs_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
